// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extend_pipe
//  Description : Pipelined immediate-extension stage (sign / zero / upper /
//                branch offset) with a valid/ready handshake.
//                Optional macro IMM_EXT_SKID_EN adds a 1-entry skid buffer so
//                in_ready is a register output with no combinational path
//                from out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  IN,
   input  logic [1:0]       MODE,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] OUT,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [1:0] c_mode_sign   = 2'b00;
   localparam logic [1:0] c_mode_zero   = 2'b01;
   localparam logic [1:0] c_mode_upper  = 2'b10;
   localparam logic [1:0] c_mode_branch = 2'b11;

   logic [OUT_W-1:0] w_sign;
   logic [OUT_W-1:0] w_zero;
   logic [OUT_W-1:0] w_upper;
   logic [OUT_W-1:0] w_branch;
   logic [OUT_W-1:0] w_ext;
   logic             w_in_xfer;

   logic [OUT_W-1:0] r_out;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_out_valid;

   // When the widths match there is nothing to pad, so every mode but
   // BRANCH degenerates to the raw immediate.
   generate
      if (OUT_W > IN_W) begin : g_wide
         assign w_sign  = {{(OUT_W-IN_W){IN[IN_W-1]}}, IN};
         assign w_zero  = {{(OUT_W-IN_W){1'b0}}, IN};
         assign w_upper = {IN, {(OUT_W-IN_W){1'b0}}};
      end else begin : g_equal
         assign w_sign  = IN;
         assign w_zero  = IN;
         assign w_upper = IN;
      end
   endgenerate

   // Branch offset is a word offset: shift drops the top two bits.
   assign w_branch = w_sign << 2;

   // Select the extension for the current mode.
   always_comb begin
      w_ext = w_sign;
      case (MODE)
         c_mode_sign   : w_ext = w_sign;
         c_mode_zero   : w_ext = w_zero;
         c_mode_upper  : w_ext = w_upper;
         c_mode_branch : w_ext = w_branch;
         default       : w_ext = w_sign;
      endcase
   end

   assign w_in_xfer = in_valid && in_ready;
   assign out_valid = r_out_valid;
   assign OUT       = r_out;
   assign out_tag   = r_out_tag;

`ifdef IMM_EXT_SKID_EN
   logic [OUT_W-1:0] r_skid;
   logic [TAG_W-1:0] r_skid_tag;
   logic             r_skid_full;

   // in_ready depends only on state, breaking the out_ready -> in_ready path.
   assign in_ready = !r_skid_full;

   // Output register plus skid entry: a result arriving while the output is
   // stalled parks in the skid, and moves forward as soon as the output drains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out       <= '0;
         r_out_tag   <= '0;
         r_out_valid <= 1'b0;
         r_skid      <= '0;
         r_skid_tag  <= '0;
         r_skid_full <= 1'b0;
      end else if (r_skid_full) begin
         if (out_ready) begin
            r_out       <= r_skid;
            r_out_tag   <= r_skid_tag;
            r_skid_full <= 1'b0;
         end
      end else if (w_in_xfer) begin
         if (!r_out_valid || out_ready) begin
            r_out       <= w_ext;
            r_out_tag   <= in_tag;
            r_out_valid <= 1'b1;
         end else begin
            r_skid      <= w_ext;
            r_skid_tag  <= in_tag;
            r_skid_full <= 1'b1;
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
`else
   // Single output register: accept whenever it is empty or being drained.
   assign in_ready = !r_out_valid || out_ready;

   // Load on an input transfer; otherwise an output transfer empties the stage
   // while the data bits keep their last value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out       <= '0;
         r_out_tag   <= '0;
         r_out_valid <= 1'b0;
      end else if (w_in_xfer) begin
         r_out       <= w_ext;
         r_out_tag   <= in_tag;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_extend_pipe
//  Description : Scoreboard testbench for imm_extend_pipe with directed
//                vectors (default 16 -> 32 bit, 5-bit tag).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  tag;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] IN;
   logic [1:0]  MODE;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] OUT;
   logic [4:0]  out_tag;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   int   cyc    = 0;
   int   pop_cyc[$];

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .IN        (IN),
      .MODE      (MODE),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .OUT       (OUT),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every output transfer is popped and compared in order.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_output", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_data", OUT, e.data);
            chk("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
         end
         pop_cyc.push_back(cyc);
      end
   end

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   // Present one operand, hold it until accepted, record the expectation.
   task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag, input logic [31:0] exp, output int waits);
      bit done;
      IN = imm; MODE = mode; in_tag = tag; in_valid = 1'b1;
      waits = 0;
      done  = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back('{data: exp, tag: tag});
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && q.size() != 0; t++) begin
         @(negedge clk);
         #1;
      end
      chk("drain_empty", q.size(), 32'd0);
      align();
   endtask

   logic [15:0] s_imm  [8] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hABCD,
                               16'h4000, 16'h8000, 16'h7FFF, 16'h0001};
   logic [1:0]  s_mode [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10};
   logic [31:0] s_exp  [8] = '{32'h00000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'hABCD0000,
                               32'h00010000, 32'hFFFE0000, 32'h00007FFF, 32'h00010000};

   logic [15:0] b_imm  [3] = '{16'h7FFF, 16'h00FF, 16'h8001};
   logic [1:0]  b_mode [3] = '{2'b00, 2'b10, 2'b11};
   logic [31:0] b_exp  [3] = '{32'h00007FFF, 32'h00FF0000, 32'hFFFE0004};

   logic [15:0] d_imm  [4] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
   logic [1:0]  d_mode [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
   logic [31:0] d_exp  [4] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC};

   initial begin
      int          waits;
      int          k;
      int          p0;
      bit          seen;
      logic [31:0] hold_out;
      logic [4:0]  hold_tag;
      int          bp_exp;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      IN = '0; MODE = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out", OUT, 32'd0);
      chk("rst_tag", {27'd0, out_tag}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      align();

      // Single operands: each mode, one-cycle latency.
      for (int i = 0; i < 4; i++) begin
         send(d_imm[i], d_mode[i], 5'(i + 20), d_exp[i], waits);
         in_valid = 1'b0;
         @(negedge clk);
         chk("latency_valid", {31'd0, out_valid}, 32'd1);
         align();
      end
      send(16'h0001, 2'b11, 5'd24, 32'h00000004, waits);
      in_valid = 1'b0;
      drain();

      // Back-pressure: five stalled cycles with the input held valid.
`ifdef IMM_EXT_SKID_EN
      bp_exp = 2;
`else
      bp_exp = 1;
`endif
      out_ready = 1'b0;
      k = 0;
      seen = 1'b0;
      hold_out = '0;
      hold_tag = '0;
      for (int c = 0; c < 5; c++) begin
         IN = b_imm[k]; MODE = b_mode[k]; in_tag = 5'(k + 10); in_valid = 1'b1;
         @(negedge clk);
         if (out_valid) begin
            if (!seen) begin
               seen = 1'b1;
               hold_out = OUT;
               hold_tag = out_tag;
            end else begin
               chk("stall_out", OUT, hold_out);
               chk("stall_tag", {27'd0, out_tag}, {27'd0, hold_tag});
            end
         end
         if (in_ready && k < 2) begin
            q.push_back('{data: b_exp[k], tag: 5'(k + 10)});
            k++;
         end
         align();
      end
      in_valid = 1'b0;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_accepted", k, bp_exp);
      out_ready = 1'b1;
      drain();

      // Streaming: full throughput with tags 0..7.
      p0 = pop_cyc.size();
      for (int i = 0; i < 8; i++) begin
         send(s_imm[i], s_mode[i], 5'(i), s_exp[i], waits);
         chk("stream_no_wait", waits, 32'd0);
      end
      in_valid = 1'b0;
      drain();
      chk("stream_count", pop_cyc.size() - p0, 32'd8);
      if (pop_cyc.size() >= p0 + 8)
         chk("stream_back_to_back", pop_cyc[p0 + 7] - pop_cyc[p0], 32'd7);

      // Asynchronous reset while stalled with valid output.
      out_ready = 1'b0;
      send(16'h1234, 2'b01, 5'd9, 32'h00001234, waits);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_out", OUT, 32'd0);
      chk("async_rst_tag", {27'd0, out_tag}, 32'd0);
      q.delete();
      align();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      align();
      out_ready = 1'b1;

      // One more operand after reset to confirm the stage recovers.
      send(16'hFFFE, 2'b00, 5'd31, 32'hFFFFFFFE, waits);
      in_valid = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
